// File: rtl/if_id_queue.sv
// Fetch-to-decode bundle FIFO: registered-only ready/valid, FIFO ordering,
// and a flush that drops every wrong-path entry.
module if_id_queue #(
  parameter int BUS_W = 97,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [BUS_W-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [BUS_W-1:0] out_data,
  input  logic             out_ready,
  input  logic             flush,
  output logic [CNT_W-1:0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr, rd_ptr;
  logic [BUS_W-1:0] mem [DEPTH];
  logic             empty, full, push, pop;

  // Wrap bit disambiguates full from empty when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign count     = CNT_W'(wr_ptr - rd_ptr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr[AW-1:0]] <= in_data;
  end
endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue: a queue model predicts occupancy and head.
module tb_if_id_queue;
  localparam int BUS_W = 97;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clk, rst, in_valid, out_ready, flush;
  logic [BUS_W-1:0] in_data;
  logic             in_ready, out_valid;
  logic [BUS_W-1:0] out_data;
  logic [CNT_W-1:0] count;

  logic [BUS_W-1:0] sb [$];
  int checks = 0;
  int errors = 0;

  if_id_queue #(.BUS_W(BUS_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .flush(flush), .count(count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  function automatic logic [BUS_W-1:0] mk(input logic [31:0] pc, input logic [31:0] instr);
    return {pc, instr, pc + 32'd4, pc[2]};
  endfunction

  // Drive one cycle, check outputs at the falling edge, then update the model.
  task automatic cycle(input logic v, input logic [BUS_W-1:0] d, input logic ordy, input logic fl);
    int n;
    in_valid = v; in_data = d; out_ready = ordy; flush = fl;
    @(negedge clk);
    n = sb.size();
    chk("in_ready", in_ready, n < DEPTH);
    chk("out_valid", out_valid, n > 0);
    chk("count", count, n);
    chk("out_data", out_data, n > 0 ? sb[0] : '0);
    if (fl) sb.delete();
    else begin
      if (ordy && n > 0) void'(sb.pop_front());
      if (v && n < DEPTH) sb.push_back(d);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle_checks(input string tag);
    chk({tag, "_valid"}, out_valid, 1'b0);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_ready"}, in_ready, 1'b1);
    chk({tag, "_data"}, out_data, '0);
  endtask

  initial begin
    logic [31:0] pc;
    int sent, n;
    rst = 1'b0; in_valid = 1'b1; in_data = mk(32'h80000000, 32'h00000413);
    out_ready = 1'b0; flush = 1'b0;
    #2 idle_checks("rst0");
    repeat (2) @(posedge clk);
    #1 idle_checks("rst1");
    rst = 1'b1;

    // first push after release
    cycle(1'b1, mk(32'h80000000, 32'h00000413), 1'b0, 1'b0);
    chk("first_pc", out_data[96:65], 32'h80000000);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);   // pop while empty: ignored

    // fill to full, fifth refused, then drain in order
    for (int i = 0; i < 5; i++) cycle(1'b1, mk(32'h80000000 + 32'(4*i), 32'h13), 1'b0, 1'b0);
    chk("full_count", count, 4);
    chk("full_ready", in_ready, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc", out_data[96:65], 32'h80000000 + 32'(4*i));
      cycle(1'b0, '0, 1'b1, 1'b0);
    end

    // full with simultaneous push and pop: push refused, then accepted
    for (int i = 0; i < 4; i++) cycle(1'b1, mk(32'h80000040 + 32'(4*i), 32'h13), 1'b0, 1'b0);
    cycle(1'b1, mk(32'h80000050, 32'h13), 1'b1, 1'b0);
    chk("simul_count", count, 3);
    cycle(1'b1, mk(32'h80000050, 32'h13), 1'b0, 1'b0);
    chk("simul_count2", count, 4);
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b0);

    // wrap-around streaming with out_ready 1,1,0
    pc = 32'h80001000; sent = 0;
    for (int i = 0; i < 80 && (sent < 20 || sb.size() > 0); i++) begin
      n = sb.size();
      cycle(sent < 20, mk(pc, 32'h00100093 + pc), (i % 3) != 2, 1'b0);
      if (sent < 20 && n < DEPTH) begin sent++; pc += 32'd4; end
    end
    chk("stream_sent", sent, 20);
    chk("stream_drained", out_valid, 1'b0);

    // flush with pending push and pop
    for (int i = 0; i < 3; i++) cycle(1'b1, mk(32'h80000080 + 32'(4*i), 32'h13), 1'b0, 1'b0);
    cycle(1'b1, mk(32'h80000100, 32'h13), 1'b1, 1'b1);
    idle_checks("flush");
    cycle(1'b1, mk(32'h80000200, 32'h13), 1'b0, 1'b0);
    chk("redirect_pc", out_data[96:65], 32'h80000200);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);

    // async reset mid-stream
    cycle(1'b1, mk(32'h80000300, 32'h13), 1'b0, 1'b0);
    cycle(1'b1, mk(32'h80000304, 32'h13), 1'b0, 1'b0);
    chk("pre_rst_count", count, 2);
    in_valid = 1'b0; out_ready = 1'b0;
    #2 rst = 1'b0;
    #1 idle_checks("async_rst");
    sb.delete();
    @(posedge clk); #1 rst = 1'b1;
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b1, mk(32'h80000400, 32'h13), 1'b0, 1'b0);
    chk("post_rst_pc", out_data[96:65], 32'h80000400);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
